// File: rtl/ram_param_clr.sv
`default_nettype none
// ============================================================================
// ram_param_clr - parametrised single-port RAM with zeroing sweep, rev 1.0
// ============================================================================
module ram_param_clr #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  // Priority reset > clear > load; the sweep owns the write port while running.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    wr_en        = 1'b0;
    wr_addr      = address;
    wr_data      = value;
    if (reset) begin
      state_d      = SWEEP;
      sweep_addr_d = '0;
    end else if (state_q == SWEEP) begin
      wr_en        = 1'b1;
      wr_addr      = sweep_addr_q;
      wr_data      = '0;
      sweep_addr_d = sweep_addr_q + ADDR_W'(1);
      if (sweep_addr_q == {ADDR_W{1'b1}}) begin
        state_d = IDLE;
      end
    end else if (clear) begin
      state_d      = SWEEP;
      sweep_addr_d = '0;
    end else if (load) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    sweep_addr_q <= sweep_addr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign busy = (state_q == SWEEP);
  assign out  = busy ? '0 : mem[address];

endmodule
`default_nettype wire

// File: tb/tb_ram_param_clr.sv
`default_nettype none
// ============================================================================
// tb_ram_param_clr - directed scoreboard bench for ram_param_clr, rev 1.0
// ============================================================================
module tb_ram_param_clr;

  localparam int DEPTH = 4096;
  localparam int BOUND = 5000;

  logic        clk = 1'b0;
  logic        reset, clear, load;
  logic [11:0] address;
  logic [15:0] value;
  logic [15:0] out;
  logic        busy;

  logic        s_reset, s_clear, s_load;
  logic [2:0]  s_address;
  logic [7:0]  s_value;
  logic [7:0]  s_out;
  logic        s_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ram_param_clr dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .address(address), .value(value), .out(out), .busy(busy)
  );

  ram_param_clr #(.WIDTH(8), .ADDR_W(3)) dut_small (
    .clk(clk), .reset(s_reset), .clear(s_clear), .load(s_load),
    .address(s_address), .value(s_value), .out(s_out), .busy(s_busy)
  );

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %0h expected none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_big(input string tag, input logic [11:0] a, input logic [15:0] exp);
    address = a;
    push(tag, {16'h0, exp});
    #1;
    pop_check({16'h0, out});
  endtask

  task automatic read_small(input string tag, input logic [2:0] a, input logic [7:0] exp);
    s_address = a;
    push(tag, {24'h0, exp});
    #1;
    pop_check({24'h0, s_out});
  endtask

  // Counts edges from now until busy drops, checking out stays 0 meanwhile.
  task automatic run_sweep(input string tag, input int clear_at, input bit hold_load);
    int n;
    int out_bad;
    n = 0;
    out_bad = 0;
    push({tag, "_len"}, DEPTH);
    push({tag, "_out_zero"}, 0);
    while (busy === 1'b1 && n < BOUND) begin
      clear   = (n + 1 == clear_at);
      load    = hold_load && (n + 1 < DEPTH - 50);
      address = 12'd5;
      value   = 16'hABCD;
      #1;
      if (out !== 16'h0) out_bad++;
      tick();
      n++;
    end
    clear = 1'b0;
    load  = 1'b0;
    pop_check(n);
    pop_check(out_bad);
  endtask

  initial begin
    int n;
    reset = 1'b1; clear = 1'b0; load = 1'b0; address = '0; value = '0;
    s_reset = 1'b0; s_clear = 1'b0; s_load = 1'b0; s_address = '0; s_value = '0;

    // Power-on reset sweep
    tick();
    reset = 1'b0;
    push("reset_busy", 1);
    pop_check(busy);
    read_big("reset_out", 12'd643, 16'h0);
    run_sweep("reset_sweep", 0, 1'b0);
    read_big("sweep_rd0", 12'd0, 16'h0);
    read_big("sweep_rd643", 12'd643, 16'h0);
    read_big("sweep_rd4095", 12'd4095, 16'h0);

    // Write / read, same-edge visibility and no early bypass
    load = 1'b1; address = 12'd643; value = 16'h0003;
    tick();
    push("write_visible", 16'h0003);
    pop_check(out);
    address = 12'd2669; value = 16'h000F;
    push("before_write_old", 16'h0);
    #1;
    pop_check(out);
    tick();
    load = 1'b0;
    read_big("rd643", 12'd643, 16'h0003);
    read_big("rd2669", 12'd2669, 16'h000F);

    // Boundary words
    load = 1'b1; address = 12'd4095; value = 16'hBEEF;
    tick();
    address = 12'd0; value = 16'hCAFE;
    tick();
    load = 1'b0;
    read_big("rd4095_bnd", 12'd4095, 16'hBEEF);
    read_big("rd0_bnd", 12'd0, 16'hCAFE);

    // Clear beats a simultaneous load
    clear = 1'b1; load = 1'b1; address = 12'd100; value = 16'h1234;
    tick();
    clear = 1'b0; load = 1'b0;
    push("clear_busy", 1);
    pop_check(busy);
    run_sweep("clear_sweep", 0, 1'b0);
    read_big("clr_rd643", 12'd643, 16'h0);
    read_big("clr_rd100", 12'd100, 16'h0);
    read_big("clr_rd4095", 12'd4095, 16'h0);

    // Reset mid-sweep restarts; clear mid-sweep and load are ignored
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load = 1'b1; address = 12'd5; value = 16'hABCD;
    for (int i = 1; i < 2000; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("midreset_busy", 1);
    pop_check(busy);
    run_sweep("midreset_sweep", 1000, 1'b1);
    read_big("blocked_rd5", 12'd5, 16'h0);

    // Small instance: 8-word sweep and extreme addresses
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    n = 0;
    push("small_sweep_len", 8);
    while (s_busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    pop_check(n);
    s_load = 1'b1; s_address = 3'd7; s_value = 8'hFF;
    tick();
    s_address = 3'd0; s_value = 8'h01;
    tick();
    s_load = 1'b0;
    read_small("small_rd7", 3'd7, 8'hFF);
    read_small("small_rd0", 3'd0, 8'h01);
    read_small("small_rd3", 3'd3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
